kernel_stream_driver: RTL and testbench

- Drives a stall-controlled, fixed-latency map kernel from the host side.
- Accepts a valid/ready input stream and presents one word per cycle to the kernel data input.
- Generates the kernel's global stall and tracks items in flight through the kernel pipeline.
- Captures kernel results into an output FIFO exposed as a valid/ready stream, and signals completion after a programmed item count.

---
 rtl/kernel_stream_driver_pkg.sv | 15 +
 rtl/kernel_stream_driver_fifo.sv | 47 ++++
 rtl/kernel_stream_driver.sv | 107 ++++++++++
 tb/tb_kernel_stream_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/kernel_stream_driver_pkg.sv
// Shared types and helpers for the kernel stream driver and its output FIFO.
package kernel_stream_driver_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int DATAW_DEF = 32;
  localparam int CNTW_DEF  = 16;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

endpackage

// File: rtl/kernel_stream_driver_fifo.sv
// Show-ahead FIFO: rdata is always the head entry, count tracks occupancy.
module sync_fifo_fwft
  import kernel_stream_driver_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATAW-1:0]           wdata,
  input  logic                       pop,
  output logic [DATAW-1:0]           rdata,
  output logic [clog2(DEPTH):0]      count
);
  localparam int AW = clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rdata = mem[rptr];

  // The driver's room check must make both of these unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == (AW+1)'(DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/kernel_stream_driver.sv
// Host-side driver for a stall-controlled fixed-latency kernel: feeds input,
// tracks in-flight items and collects results into an output FIFO.
module kernel_stream_driver
  import kernel_stream_driver_pkg::*;
#(
  parameter int DATAW      = DATAW_DEF,
  parameter int KLAT       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNTW-1:0]  nitems,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] k_vin,
  output logic             k_stall,
  input  logic [DATAW-1:0] k_vout,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam int AW = clog2(FIFO_DEPTH);

  state_t          state;
  logic [CNTW-1:0] n_q, issued, popped;
  logic [KLAT-1:0] vbit;
  logic [AW:0]     inflight, fcount;
  logic            room, adv, issue, push, pop;

  // Conservative: a same-cycle pop is not credited, so no overflow is possible.
  assign room = ({1'b0, fcount} + {1'b0, inflight}) < (AW+2)'(FIFO_DEPTH);

  always_comb begin
    adv = 1'b0;
    case (state)
      S_RUN:   adv = room && in_valid;
      S_DRAIN: adv = room && (inflight != '0);
      default: adv = 1'b0;
    endcase
  end

  assign issue     = adv && (state == S_RUN);
  assign in_ready  = issue;
  assign k_stall   = !adv;
  assign k_vin     = issue ? in_data : '0;
  assign push      = adv && vbit[KLAT-1];
  assign out_valid = (fcount != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbit     <= '0;
      inflight <= '0;
    end else begin
      if (adv) vbit <= KLAT'({vbit, issue});
      inflight <= inflight + (AW+1)'(issue) - (AW+1)'(push);
    end
  end

  // RUN leaves on the edge of the final issue so no extra item slips in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      n_q    <= '0;
      issued <= '0;
      popped <= '0;
    end else begin
      if (pop) popped <= popped + CNTW'(1);
      case (state)
        S_IDLE: if (start) begin
          if (nitems != '0) begin
            n_q    <= nitems;
            issued <= '0;
            popped <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_DONE;
          end
        end
        S_RUN: if (issue) begin
          issued <= issued + CNTW'(1);
          if (issued + CNTW'(1) == n_q) state <= S_DRAIN;
        end
        S_DRAIN: if (pop && (popped + CNTW'(1) == n_q)) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(.DATAW(DATAW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (k_vout),
    .pop   (pop),
    .rdata (out_data),
    .count (fcount)
  );

endmodule

// File: tb/tb_kernel_stream_driver.sv
// Randomized bench: +1 kernel model with stall, scoreboard queue of expected results.
`timescale 1ns/1ps
module tb_kernel_stream_driver;
  localparam int DATAW = 32;
  localparam int KLAT  = 4;
  localparam int DEPTH = 8;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, k_stall, out_valid, out_ready, busy, done;
  logic [CNTW-1:0]  nitems;
  logic [DATAW-1:0] in_data, k_vin, k_vout, out_data;

  always #5 clk = ~clk;

  kernel_stream_driver #(.DATAW(DATAW), .KLAT(KLAT), .FIFO_DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .nitems(nitems),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .k_vin(k_vin), .k_stall(k_stall), .k_vout(k_vout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Kernel: KLAT-deep map pipeline computing x+1, frozen while stalled.
  logic [DATAW-1:0] kpipe [KLAT];
  always @(posedge clk) begin
    if (!k_stall) begin
      kpipe[0] <= k_vin + DATAW'(1);
      for (int i = 1; i < KLAT; i++) kpipe[i] <= kpipe[i-1];
    end
  end
  assign k_vout = kpipe[KLAT-1];

  int n_chk, n_err;
  int cyc, rc, cur_n, cur_mode;
  int sent, popped, done_cnt, first_in, first_out, last_pop;
  logic [DATAW-1:0] exp_q [$];

  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_k_stall"}, k_stall, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_k_vin"}, k_vin, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // Observes the cycle's handshakes at the negedge, before the edge commits them.
  task mon();
    cyc++;
    if (rst) return;
    if (cur_mode == 1 && rc == 30) begin
      chk("bp_outstanding", sent - popped, DEPTH);
      chk("bp_stall", k_stall, 1);
    end
    if (busy && sent < cur_n) begin
      if (cur_mode == 0) chk("run_no_stall", k_stall, 0);
      if (cur_mode == 2) chk("stall_follows_valid", k_stall, !in_valid);
    end
    if (!busy) chk("ready_idle", in_ready, 0);
    if (in_valid && in_ready) begin
      chk("k_vin", k_vin, in_data);
      exp_q.push_back(DATAW'(in_data + 1));
      if (first_in < 0) first_in = cyc;
      sent++;
    end else if (busy) begin
      chk("k_vin_bubble", k_vin, 0);
    end
    if (out_valid && first_out < 0) first_out = cyc;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_data, -1);
      else chk("out_data", out_data, exp_q.pop_front());
      popped++;
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_pops", popped, cur_n);
      if (cur_n > 0) chk("done_lat", cyc - last_pop, 1);
    end
  endtask

  task automatic clear_sb(input int n, input int mode);
    cur_n = n; cur_mode = mode; rc = 0;
    sent = 0; popped = 0; done_cnt = 0; first_in = -1; first_out = -1; last_pop = 0;
    exp_q.delete();
  endtask

  task automatic set_inputs();
    bit more;
    more = (sent < cur_n);
    case (cur_mode)
      0: begin in_valid = more; out_ready = 1'b1; end
      1: begin in_valid = more; out_ready = !(rc >= 3 && rc <= 30); end
      2: begin in_valid = more && (rc % 2 == 1); out_ready = 1'b1; end
      default: begin in_valid = more && ($urandom_range(3) != 0); out_ready = ($urandom_range(2) != 0); end
    endcase
    in_data = (cur_mode == 0) ? DATAW'(sent + 1) : DATAW'($urandom);
  endtask

  task automatic run(input int n, input int mode, input bit restart);
    clear_sb(n, mode);
    start = 1'b1; nitems = CNTW'(n); set_inputs();
    @(posedge clk); #1;
    rc = 1;
    while (done_cnt == 0 && rc < 3000) begin
      set_inputs();
      start = restart && (rc == 3);
      if (start) nitems = CNTW'(2);
      @(posedge clk); #1;
      rc++;
    end
    start = 1'b0;
    repeat (4) begin set_inputs(); @(posedge clk); #1; rc++; end
    in_valid = 1'b0;
    chk("run_done_once", done_cnt, 1);
    chk("run_pops", popped, n);
    chk("run_sent", sent, n);
    chk("run_sb_empty", exp_q.size(), 0);
    if (mode == 0) chk("first_latency", first_out - first_in, KLAT + 1);
  endtask

  initial begin
    int k;
    n_chk = 0; n_err = 0; cyc = 0;
    clear_sb(0, 4);
    rst = 1'b1; start = 1'b0; nitems = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    fork
      forever begin @(negedge clk); mon(); end
      begin #1000000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end
    join_none
    repeat (2) @(posedge clk);
    #1 chk_rst_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run(10, 0, 0);
    run(20, 1, 0);
    run(16, 2, 0);

    // Zero-length run
    clear_sb(0, 4);
    start = 1'b1; nitems = '0;
    @(negedge clk); chk("zl_done_early", done, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zl_done", done, 1);
    chk("zl_in_ready", in_ready, 0);
    chk("zl_k_stall", k_stall, 1);
    @(negedge clk); chk("zl_done_clear", done, 0);
    chk("zl_done_cnt", done_cnt, 1);
    @(posedge clk); #1;

    run(30, 3, 0);
    run(12, 0, 1);

    // Reset while draining with three items in flight
    clear_sb(3, 4);
    start = 1'b1; nitems = CNTW'(3); in_valid = 1'b1; out_ready = 1'b0; in_data = $urandom;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (sent < 3 && k < 50) begin in_data = $urandom; @(posedge clk); #1; k++; end
    in_valid = 1'b0;
    chk("pre_rst_sent", sent, 3);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_rst_vals("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    run(5, 0, 0);
    run(40, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
